// File: rtl/logit_frame_sequencer_pkg.sv
// Shared types and constants for the logit frame sequencer slice.
package cnn_acc_pkg;

  // Default score width in bits (signed two's complement).
  localparam int DATA_W_DEF = 32;

  // Width of a class index / beat counter.
  localparam int IDX_W = 4;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CLEAR  = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    RESULT = 3'd5
  } state_e;

  // Most-negative two's complement value of the given width (only the sign bit set).
  function automatic logic [63:0] min_score(input int unsigned width);
    logic [63:0] v;
    v = 64'd1 << (width - 32'd1);
    return v;
  endfunction

endpackage

// File: rtl/logit_frame_sequencer_if.sv
// Score stream and result handshake between the sequencer and its neighbours.
interface logit_frame_sequencer_if
  import cnn_acc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              r_valid;
  logic              r_ready;
  logic [IDX_W-1:0]  r_index;
  logic              r_err_len;
  logic              r_err_tmo;

  modport master (
    output s_valid, s_data, s_last, r_ready,
    input  s_ready, r_valid, r_index, r_err_len, r_err_tmo
  );

  modport slave (
    input  s_valid, s_data, s_last, r_ready,
    output s_ready, r_valid, r_index, r_err_len, r_err_tmo
  );
endinterface

// File: rtl/logit_frame_sequencer_buffer.sv
// Per-class score slots: write decode, most-negative padding on short frames,
// and the packed view handed to the argmax engine.
module frame_score_buffer
  import cnn_acc_pkg::*;
#(
  parameter int NUM_CLASSES = 9,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          wr_en,
  input  logic                          pad_en,
  input  logic [IDX_W-1:0]              wr_idx,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [NUM_CLASSES*DATA_W-1:0] scores
);
  localparam logic [63:0]       MIN_FULL = min_score(DATA_W);
  localparam logic [DATA_W-1:0] MIN_VAL  = MIN_FULL[DATA_W-1:0];

  logic [DATA_W-1:0]      slot_r [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] wr_sel_s;
  logic [NUM_CLASSES-1:0] pad_sel_s;

  // Decode which slot takes the beat and which slots beyond it get padded.
  always_comb begin
    wr_sel_s  = '0;
    pad_sel_s = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      wr_sel_s[k]  = wr_en && (wr_idx == IDX_W'(k));
      pad_sel_s[k] = pad_en && (IDX_W'(k) > wr_idx);
    end
  end

  // Slot registers: beat write has priority over padding, otherwise hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_CLASSES; k++) slot_r[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        if (wr_sel_s[k])       slot_r[k] <= wr_data;
        else if (pad_sel_s[k]) slot_r[k] <= MIN_VAL;
        else                   slot_r[k] <= slot_r[k];
      end
    end
  end

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_pack
    assign scores[g*DATA_W +: DATA_W] = slot_r[g];
  end

endmodule

// File: rtl/logit_frame_sequencer.sv
// Collects one frame of class scores, runs the argmax engine through a
// clear/start/done sequence and returns the winning index with error flags.
module logit_frame_sequencer
  import cnn_acc_pkg::*;
#(
  parameter int NUM_CLASSES = 9,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                          clk,
  input  logic                          resetn,
  logit_frame_sequencer_if.slave        bus,
  output logic                          am_resetn,
  output logic                          am_start,
  output logic [NUM_CLASSES*DATA_W-1:0] am_scores,
  input  logic                          am_done,
  input  logic [IDX_W-1:0]              am_index
);
  localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(NUM_CLASSES);
  localparam logic [IDX_W-1:0] CNT_MAX  = {IDX_W{1'b1}};
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_e           state_r;
  logic [IDX_W-1:0] cnt_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             s_ready_r;
  logic             am_resetn_r;
  logic             am_start_r;
  logic             r_valid_r;
  logic [IDX_W-1:0] r_index_r;
  logic             err_len_r;
  logic             err_tmo_r;

  logic             beat_acc_s;
  logic             slot_free_s;
  logic [IDX_W-1:0] cnt_next_s;

  assign beat_acc_s  = bus.s_valid & s_ready_r;
  assign slot_free_s = (cnt_r < N_IDX);

  // Beat counter advance, saturating at its all-ones value.
  always_comb begin
    cnt_next_s = cnt_r;
    if (cnt_r == CNT_MAX) cnt_next_s = CNT_MAX;
    else                  cnt_next_s = cnt_r + 4'd1;
  end

  frame_score_buffer #(
    .NUM_CLASSES (NUM_CLASSES),
    .DATA_W      (DATA_W)
  ) u_buf (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (beat_acc_s & slot_free_s),
    .pad_en  (beat_acc_s & bus.s_last),
    .wr_idx  (cnt_r),
    .wr_data (bus.s_data),
    .scores  (am_scores)
  );

  // Frame sequencing FSM with all handshake and engine controls registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      tmo_cnt_r   <= '0;
      s_ready_r   <= 1'b0;
      am_resetn_r <= 1'b0;
      am_start_r  <= 1'b0;
      r_valid_r   <= 1'b0;
      r_index_r   <= '0;
      err_len_r   <= 1'b0;
      err_tmo_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE, LOAD: begin
          s_ready_r   <= 1'b1;
          am_resetn_r <= 1'b1;
          am_start_r  <= 1'b0;
          if (beat_acc_s) begin
            cnt_r <= cnt_next_s;
            if (bus.s_last) begin
              state_r     <= CLEAR;
              s_ready_r   <= 1'b0;
              am_resetn_r <= 1'b0;
              if (!slot_free_s || (cnt_next_s != N_IDX)) err_len_r <= 1'b1;
            end else begin
              state_r <= LOAD;
              if (!slot_free_s) err_len_r <= 1'b1;
            end
          end
        end
        CLEAR: begin
          // Engine sees am_resetn low for this one cycle, dropping any stale done.
          am_resetn_r <= 1'b1;
          am_start_r  <= 1'b1;
          tmo_cnt_r   <= '0;
          state_r     <= START;
        end
        START: begin
          // Counter already runs here so the abort lands TIMEOUT_CYC cycles after the strobe.
          am_start_r <= 1'b0;
          tmo_cnt_r  <= tmo_cnt_r + TMO_W'(1);
          state_r    <= WAIT;
        end
        WAIT: begin
          if (am_done) begin
            r_index_r <= am_index;
            r_valid_r <= 1'b1;
            state_r   <= RESULT;
          end else if (tmo_cnt_r == TMO_LAST) begin
            err_tmo_r <= 1'b1;
            r_index_r <= '0;
            r_valid_r <= 1'b1;
            state_r   <= RESULT;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        RESULT: begin
          if (bus.r_ready) begin
            r_valid_r <= 1'b0;
            cnt_r     <= '0;
            err_len_r <= 1'b0;
            err_tmo_r <= 1'b0;
            s_ready_r <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= '0;
          s_ready_r   <= 1'b0;
          am_resetn_r <= 1'b0;
          am_start_r  <= 1'b0;
          r_valid_r   <= 1'b0;
          err_len_r   <= 1'b0;
          err_tmo_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready   = s_ready_r;
  assign bus.r_valid   = r_valid_r;
  assign bus.r_index   = r_index_r;
  assign bus.r_err_len = err_len_r;
  assign bus.r_err_tmo = err_tmo_r;
  assign am_resetn     = am_resetn_r;
  assign am_start      = am_start_r;

endmodule
